// File: rtl/param_dm_cache.sv
// Direct-mapped, write-through, no-write-allocate cache with whole-line refill,
// single-cycle flush and saturating hit/miss counters.
module param_dm_cache #(
  parameter int ADDR_W   = 15,
  parameter int INDEX_W  = 10,
  parameter int OFFSET_W = 2,
  parameter int WORD_W   = 32,
  parameter int CNT_W    = 16,
  localparam int TAG_W   = ADDR_W - INDEX_W - OFFSET_W,
  localparam int LINE_W  = WORD_W * (2**OFFSET_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [WORD_W-1:0] cpu_wdata,
  output logic [WORD_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  output logic              hit,
  input  logic              flush,
  output logic              mem_rd_req,
  output logic              mem_wr_req,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);
  localparam int LINES = 2**INDEX_W;
  localparam int WORDS = 2**OFFSET_W;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_WRITE, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [LINES-1:0]    valid_q;
  logic [TAG_W-1:0]    tag_q  [LINES];
  logic [LINE_W-1:0]   line_q [LINES];
  logic                req_wr_q;
  logic [ADDR_W-1:0]   req_addr_q;
  logic [WORD_W-1:0]   req_wdata_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [CNT_W-1:0]    hit_cnt_q, miss_cnt_q;

  logic [TAG_W-1:0]    req_tag;
  logic [INDEX_W-1:0]  req_idx;
  logic [OFFSET_W-1:0] req_off;
  logic                lk_hit, hit_inc, miss_inc;
  logic [LINE_W-1:0]   cur_line, wr_line;
  logic [WORD_W-1:0]   lk_word, fill_word;

  assign req_tag = req_addr_q[ADDR_W-1 -: TAG_W];
  assign req_idx = req_addr_q[OFFSET_W +: INDEX_W];
  assign req_off = req_addr_q[OFFSET_W-1:0];
  assign lk_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);

  // Offset 0 lives in the most significant word of the line.
  always_comb begin
    cur_line  = line_q[req_idx];
    wr_line   = cur_line;
    lk_word   = '0;
    fill_word = '0;
    for (int k = 0; k < WORDS; k++) begin
      if (req_off == OFFSET_W'(k)) begin
        lk_word   = cur_line[LINE_W-1-WORD_W*k -: WORD_W];
        fill_word = mem_rdata[LINE_W-1-WORD_W*k -: WORD_W];
        wr_line[LINE_W-1-WORD_W*k -: WORD_W] = req_wdata_q;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    hit_inc    = 1'b0;
    miss_inc   = 1'b0;
    cpu_ready  = 1'b0;
    hit        = 1'b0;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      S_IDLE: if (!flush && cpu_req) state_d = S_LOOKUP;
      S_LOOKUP: begin
        hit      = lk_hit;
        hit_inc  = lk_hit;
        miss_inc = !lk_hit;
        if (req_wr_q)    state_d = S_WRITE;
        else if (lk_hit) state_d = S_RESP;
        else             state_d = S_REFILL;
      end
      S_REFILL: begin
        mem_rd_req = 1'b1;
        mem_addr   = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        if (mem_ack) state_d = S_RESP;
      end
      S_WRITE: begin
        mem_wr_req = 1'b1;
        mem_addr   = req_addr_q;
        mem_wdata  = req_wdata_q;
        if (mem_ack) state_d = S_RESP;
      end
      S_RESP: begin
        cpu_ready = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      rdata_q     <= '0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (flush) begin
          valid_q <= '0;
        end else if (cpu_req) begin
          req_wr_q    <= cpu_wr;
          req_addr_q  <= cpu_addr;
          req_wdata_q <= cpu_wdata;
        end
      end
      if (state_q == S_LOOKUP && !req_wr_q && lk_hit) rdata_q <= lk_word;
      if (state_q == S_REFILL && mem_ack) begin
        valid_q[req_idx] <= 1'b1;
        rdata_q          <= fill_word;
      end
      if (hit_inc && hit_cnt_q != {CNT_W{1'b1}})   hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (miss_inc && miss_cnt_q != {CNT_W{1'b1}}) miss_cnt_q <= miss_cnt_q + 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (state_q == S_LOOKUP && req_wr_q && lk_hit) line_q[req_idx] <= wr_line;
    if (state_q == S_REFILL && mem_ack) begin
      line_q[req_idx] <= mem_rdata;
      tag_q[req_idx]  <= req_tag;
    end
  end

  assign cpu_rdata = rdata_q;
  assign hit_cnt   = hit_cnt_q;
  assign miss_cnt  = miss_cnt_q;

endmodule

// File: tb/tb_param_dm_cache.sv
// Bench for param_dm_cache: vector table with a read-data scoreboard, plus
// flush, mid-refill reset and counter saturation sequences.
module tb_param_dm_cache;
  localparam int CNT_W = 8;
  localparam logic [127:0] L1 = 128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD;
  localparam logic [127:0] L2 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] L3 = 128'h55555555_66666666_77777777_88888888;

  logic         clk = 1'b0, rst = 1'b0;
  logic         cpu_req = 1'b0, cpu_wr = 1'b0, flush = 1'b0, mem_ack = 1'b0;
  logic [14:0]  cpu_addr = '0;
  logic [31:0]  cpu_wdata = '0;
  logic [127:0] mem_rdata = '0;
  logic [31:0]  cpu_rdata, mem_wdata;
  logic [14:0]  mem_addr;
  logic         cpu_ready, hit, mem_rd_req, mem_wr_req;
  logic [CNT_W-1:0] hit_cnt, miss_cnt;

  param_dm_cache #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_wr(cpu_wr),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready), .hit(hit), .flush(flush),
    .mem_rd_req(mem_rd_req), .mem_wr_req(mem_wr_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         wr;
    logic [14:0]  addr;
    logic [31:0]  wdata;
    logic [127:0] line;
    logic         exp_hit;
    logic [31:0]  exp_rdata;
    logic [14:0]  exp_maddr;
  } vec_t;

  typedef struct {
    logic        is_rd;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[7];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int dly);
    int   n, wcnt;
    bit   done, saw_mem;
    exp_t e;
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = v.wr; cpu_addr = v.addr; cpu_wdata = v.wdata;
    sb_q.push_back('{!v.wr, v.exp_rdata});
    @(negedge clk);
    cpu_req = 1'b0;
    chk("hit_pulse", hit, v.exp_hit);
    n = 1; wcnt = 0; done = 0; saw_mem = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
      mem_ack = 1'b0;
      if (cpu_ready) begin
        done = 1;
        if (sb_q.size() == 0) chk("sb_empty", 1'b1, 1'b0);
        else begin
          e = sb_q.pop_front();
          if (e.is_rd) chk("rdata", cpu_rdata, e.data);
        end
        chk("latency", n, (!v.wr && v.exp_hit) ? 2 : 3 + dly);
      end else if (mem_rd_req || mem_wr_req) begin
        if (!saw_mem) begin
          saw_mem = 1;
          chk("mem_kind", {mem_rd_req, mem_wr_req}, v.wr ? 2'b01 : 2'b10);
          chk("mem_addr", mem_addr, v.exp_maddr);
          if (v.wr) chk("mem_wdata", mem_wdata, v.wdata);
        end
        if (wcnt == dly) begin
          mem_ack = 1'b1;
          mem_rdata = v.line;
        end
        wcnt++;
      end
    end
    mem_ack = 1'b0;
    chk("done", done, 1'b1);
    chk("mem_used", saw_mem, v.wr || !v.exp_hit);
  endtask

  initial begin
    vec_t rd;
    bit   seen;
    vecs[0] = '{1'b0, 15'h1004, 32'h0,        L1,   1'b0, 32'hAAAAAAAA, 15'h1004};
    vecs[1] = '{1'b0, 15'h1007, 32'h0,        '0,   1'b1, 32'hDDDDDDDD, 15'h0};
    vecs[2] = '{1'b1, 15'h1005, 32'h12345678, '0,   1'b1, 32'h0,        15'h1005};
    vecs[3] = '{1'b0, 15'h1005, 32'h0,        '0,   1'b1, 32'h12345678, 15'h0};
    vecs[4] = '{1'b1, 15'h2005, 32'h99999999, '0,   1'b0, 32'h0,        15'h2005};
    vecs[5] = '{1'b0, 15'h1005, 32'h0,        '0,   1'b1, 32'h12345678, 15'h0};
    vecs[6] = '{1'b0, 15'h1006, 32'h0,        '0,   1'b1, 32'hCCCCCCCC, 15'h0};

    repeat (2) @(negedge clk);
    chk("rst_ctl", {cpu_ready, hit, mem_rd_req, mem_wr_req}, 4'b0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_cnts", {hit_cnt, miss_cnt}, 0);
    rst = 1'b1;

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i % 3);
    chk("hit_cnt_a", hit_cnt, 5);
    chk("miss_cnt_a", miss_cnt, 2);

    // Flush with a simultaneous request: request must be dropped.
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h1004;
    @(negedge clk);
    flush = 1'b0; cpu_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("flush_idle", {cpu_ready, hit, mem_rd_req, mem_wr_req}, 4'b0);
      @(negedge clk);
    end
    rd = '{1'b0, 15'h1004, 32'h0, L2, 1'b0, 32'h11111111, 15'h1004};
    run_vec(rd, 1);
    chk("miss_cnt_flush", miss_cnt, 3);
    chk("hit_cnt_flush", hit_cnt, 5);

    // Reset while a refill is outstanding.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 15'h3008;
    @(negedge clk);
    cpu_req = 1'b0;
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(negedge clk);
      if (mem_rd_req) seen = 1;
    end
    chk("refill_seen", seen, 1'b1);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctl", {cpu_ready, hit, mem_rd_req, mem_wr_req}, 4'b0);
    chk("mid_rst_data", {cpu_rdata, mem_addr, mem_wdata}, 0);
    chk("mid_rst_cnts", {hit_cnt, miss_cnt}, 0);
    @(negedge clk);
    rst = 1'b1;
    mem_ack = 1'b1; mem_rdata = L3;
    @(negedge clk);
    mem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("late_ack", {cpu_ready, mem_rd_req, mem_wr_req}, 3'b0);
      @(negedge clk);
    end
    rd = '{1'b0, 15'h1004, 32'h0, L1, 1'b0, 32'hAAAAAAAA, 15'h1004};
    run_vec(rd, 0);
    rd = '{1'b0, 15'h3008, 32'h0, L3, 1'b0, 32'h55555555, 15'h3008};
    run_vec(rd, 2);
    chk("miss_cnt_rst", miss_cnt, 2);

    // Drive hit counter to saturation, then one more hit.
    rd = '{1'b0, 15'h1005, 32'h0, '0, 1'b1, 32'hBBBBBBBB, 15'h0};
    for (int i = 0; i < (2**CNT_W) - 1; i++) run_vec(rd, 0);
    chk("hit_cnt_max", hit_cnt, {CNT_W{1'b1}});
    run_vec(rd, 0);
    chk("hit_cnt_sat", hit_cnt, {CNT_W{1'b1}});
    chk("miss_cnt_end", miss_cnt, 2);
    chk("sb_drained", sb_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout act=running exp=finished");
    $fatal(1);
  end
endmodule

// File: doc/param_dm_cache.md
Name: param_dm_cache

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate cache.
- CPU side uses a req/ready handshake; memory side uses a req/ack handshake.
- On a read miss, an FSM refills the whole line from main memory.
- Adds a single-cycle flush and saturating hit/miss counters. It sits between the core's load/store unit and the main-memory controller.

Parameters:
ADDR_W, 15, word-address width
INDEX_W, 10, index bits; lines = 2**INDEX_W
OFFSET_W, 2, word-in-line bits; words per line = 2**OFFSET_W
WORD_W, 32, data word width
CNT_W, 16, hit/miss counter width
(derived) TAG_W = ADDR_W-INDEX_W-OFFSET_W; LINE_W = WORD_W*2**OFFSET_W

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
cpu_req  in  1  request valid; sampled only in IDLE
cpu_wr  in  1  1=write, 0=read
cpu_addr  in  ADDR_W  {tag,index,offset}
cpu_wdata  in  WORD_W  write data
cpu_rdata  out  WORD_W  read data; valid while cpu_ready=1
cpu_ready  out  1  one-cycle completion pulse
hit  out  1  one-cycle pulse in LOOKUP when tag matches a valid line
flush  in  1  invalidate all lines; honoured only in IDLE
mem_rd_req  out  1  line refill request
mem_wr_req  out  1  word write-through request
mem_addr  out  ADDR_W  word address; offset bits zero for refill
mem_wdata  out  WORD_W  write-through data
mem_rdata  in  LINE_W  refill line; sampled when mem_ack=1
mem_ack  in  1  memory completion, one cycle
hit_cnt  out  CNT_W  saturating count of hits
miss_cnt  out  CNT_W  saturating count of misses

Behaviour:
- Storage: valid bit, tag, and line per index, all read combinationally. Only the valid bits are reset.
- Word order: offset 0 is line bits [LINE_W-1 -: WORD_W]; offset k is WORD_W*k bits lower.
- States: IDLE, LOOKUP, REFILL, WRITE, RESP.
- IDLE:
  - If flush=1: clear all valid bits at this edge. Any cpu_req in the same cycle is ignored.
  - Else if cpu_req=1: capture cpu_wr, cpu_addr and cpu_wdata into request registers, then go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==req_tag.
  - Read hit: latch the selected word into cpu_rdata, hit_cnt++, go to RESP.
  - Read miss: miss_cnt++, go to REFILL.
  - Write hit: update only the addressed word in the line, hit_cnt++, go to WRITE.
  - Write miss: miss_cnt++, go to WRITE. The line is left untouched (no allocate).
- REFILL:
  - Hold mem_rd_req=1 and mem_addr={tag,index,0} until mem_ack.
  - On mem_ack: write mem_rdata into the line, set tag, set valid, latch the requested word into cpu_rdata, go to RESP.
- WRITE:
  - Hold mem_wr_req=1, mem_addr=req_addr and mem_wdata=req_wdata until mem_ack, then go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, then go to IDLE. cpu_rdata holds its value until the next read completes.
- Latency from the accept edge to cpu_ready: read hit 2 cycles; read miss 2 + memory wait + 1; write 2 + memory wait + 1.
- mem_ack outside REFILL/WRITE is ignored. mem_rd_req and mem_wr_req are never both high.
- Counters saturate at 2**CNT_W-1 and do not wrap.
- Reset (asynchronous, any state including mid-refill):
  - state=IDLE; all valid=0.
  - cpu_ready, hit, mem_rd_req, mem_wr_req = 0.
  - cpu_rdata, mem_addr, mem_wdata, hit_cnt, miss_cnt = 0.
  - A pending memory transaction is abandoned; a late mem_ack is ignored.
- Flush does not reset the counters.

Test Plan:
- Reset, then read addr 0x1004 -> read miss: miss_cnt=1, mem_rd_req with mem_addr=0x1004. Ack with line 0xAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD -> cpu_rdata=0xAAAAAAAA.
- Then read 0x1007 -> hit pulse, cpu_ready 2 cycles after accept, cpu_rdata=0xDDDDDDDD, hit_cnt=1, no memory request.
- Write 0x1005 data 0x12345678 -> mem_wr_req with mem_addr=0x1005. Subsequent read of 0x1005 hits, cpu_rdata=0x12345678. Write to 0x2005 (same index, new tag) -> miss, line unchanged; read 0x1005 still hits.
- Flush in IDLE, then read 0x1004 -> miss and refill again. A cpu_req asserted in the flush cycle is not accepted (cpu_ready stays 0 until re-issued).
- Assert rst during REFILL before mem_ack -> all outputs 0 and state IDLE. A later mem_ack is ignored. The next read of 0x1004 misses.
- Force hit_cnt to 0xFFFF via repeated hits -> one more hit leaves it at 0xFFFF.
